nvr_mem_ctrl: RTL

Sequencing controller for one NVR_TOP non-volatile memory macro. After reset it runs the macro power-on (POR) sequence. It then turns single-cycle processor-side read/write requests into the macro's WE-setup / CE-strobe / WE-hold / RDY-wait timing, so CE/WE/POR strobing is done in hardware rather than in bench tasks. One instance sits between the processor's data or instruction port and each NVR_TOP.

---
 rtl/nvr_mem_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nvr_mem_ctrl.sv
// Sequencer for one NVR_TOP macro: power-on POR pulse, then single-request
// read/write accesses with WE setup, CE strobe, WE hold and RDY handshake.
module nvr_mem_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int POR_CYC   = 10,
  parameter int SETUP_CYC = 2,
  parameter int CE_CYC    = 1,
  parameter int RD_CYC    = 2,
  parameter int HOLD_CYC  = 7,
  parameter int RDY_TMO   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              init_done,
  output logic [ADDR_W-1:0] nvr_a,
  output logic [DATA_W-1:0] nvr_din,
  output logic              nvr_ce,
  output logic              nvr_we,
  output logic              nvr_por,
  input  logic [DATA_W-1:0] nvr_dout,
  input  logic              nvr_rdy
);

  typedef enum logic [3:0] {
    PON_LO, PON_HI, PON_WAIT, IDLE, SETUP, STROBE, RDWAIT, HOLD, WAIT_RDY
  } state_t;

  // Counter reload values: a state lasting N cycles exits when the count hits 0.
  localparam logic [7:0] POR_LD   = 8'(POR_CYC - 1);
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] CE_LD    = 8'(CE_CYC - 1);
  localparam logic [7:0] RD_LD    = 8'(RD_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TMO_LD   = 8'(RDY_TMO - 1);

  state_t              state, state_nx;
  logic [7:0]          cnt, cnt_nx;
  logic                ready_nx, ack_nx, err_nx, init_nx;
  logic                ce_nx, we_nx, por_nx;
  logic [ADDR_W-1:0]   a_nx;
  logic [DATA_W-1:0]   din_nx, rdata_nx;
  logic                cnt_zero;

  assign cnt_zero = (cnt == 8'd0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready_nx = req_ready;
    ack_nx   = 1'b0;
    err_nx   = err;
    init_nx  = init_done;
    ce_nx    = nvr_ce;
    we_nx    = nvr_we;
    por_nx   = nvr_por;
    a_nx     = nvr_a;
    din_nx   = nvr_din;
    rdata_nx = rdata;
    case (state)
      PON_LO: begin
        if (cnt_zero) begin
          state_nx = PON_HI;
          por_nx   = 1'b1;
          cnt_nx   = POR_LD;
        end else cnt_nx = cnt - 8'd1;
      end
      PON_HI: begin
        if (cnt_zero) begin
          state_nx = PON_WAIT;
          por_nx   = 1'b0;
          cnt_nx   = TMO_LD;
        end else cnt_nx = cnt - 8'd1;
      end
      PON_WAIT: begin
        // A timeout still releases the controller; err records that RDY never came.
        if (nvr_rdy || cnt_zero) begin
          state_nx = IDLE;
          init_nx  = 1'b1;
          ready_nx = 1'b1;
          if (!nvr_rdy) err_nx = 1'b1;
        end else cnt_nx = cnt - 8'd1;
      end
      IDLE: begin
        if (req) begin
          state_nx = SETUP;
          a_nx     = req_addr;
          din_nx   = req_wdata;
          we_nx    = req_we;
          ready_nx = 1'b0;
          cnt_nx   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nx = STROBE;
          ce_nx    = 1'b1;
          cnt_nx   = CE_LD;
        end else cnt_nx = cnt - 8'd1;
      end
      STROBE: begin
        // nvr_we still carries the access direction latched at acceptance.
        if (cnt_zero) begin
          ce_nx = 1'b0;
          if (nvr_we) begin
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
          end else begin
            state_nx = RDWAIT;
            cnt_nx   = RD_LD;
          end
        end else cnt_nx = cnt - 8'd1;
      end
      RDWAIT: begin
        if (cnt_zero) begin
          state_nx = IDLE;
          rdata_nx = nvr_dout;
          ack_nx   = 1'b1;
          ready_nx = 1'b1;
        end else cnt_nx = cnt - 8'd1;
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nx = WAIT_RDY;
          we_nx    = 1'b0;
          cnt_nx   = TMO_LD;
        end else cnt_nx = cnt - 8'd1;
      end
      WAIT_RDY: begin
        if (nvr_rdy || cnt_zero) begin
          state_nx = IDLE;
          ack_nx   = 1'b1;
          ready_nx = 1'b1;
          if (!nvr_rdy) err_nx = 1'b1;
        end else cnt_nx = cnt - 8'd1;
      end
      default: state_nx = PON_LO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PON_LO;
      cnt       <= POR_LD;
      req_ready <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      init_done <= 1'b0;
      nvr_ce    <= 1'b0;
      nvr_we    <= 1'b0;
      nvr_por   <= 1'b0;
      nvr_a     <= '0;
      nvr_din   <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= ready_nx;
      ack       <= ack_nx;
      err       <= err_nx;
      init_done <= init_nx;
      nvr_ce    <= ce_nx;
      nvr_we    <= we_nx;
      nvr_por   <= por_nx;
      nvr_a     <= a_nx;
      nvr_din   <= din_nx;
      rdata     <= rdata_nx;
    end
  end

endmodule
